uart_tx_arbiter: RTL and testbench



---
 rtl/uart_tx_arbiter.sv | 178 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one 8N1 UART transmit line between NUM_REQ byte sources.
// Define UART_TX_ARB_PARITY_EN to insert an even-parity bit between DATA and STOP.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx,
    output logic                 busy,
    output logic [2:0]           grant_id,
    output logic                 frame_done
);

    localparam int unsigned          BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0]    BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]           LAST_INIT = 3'(NUM_REQ - 1);

`ifdef UART_TX_ARB_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;
`endif

    state_e              state_q, state_d;
    logic [BAUD_W-1:0]   baud_q, baud_d;
    logic [2:0]          bit_idx_q, bit_idx_d;
    logic [7:0]          data_q, data_d;
    logic [2:0]          last_grant_q, last_grant_d;
    logic [2:0]          grant_id_q, grant_id_d;

    logic                bit_end;
    logic                found;
    logic [2:0]          winner;
    logic [2:0]          cand;
    logic                accept;
    logic [7:0]          valid_ext;
    logic [7:0]          req_byte [8];

    // Pad requester slots up to eight so non-existent indices read as idle zeros.
    for (genvar g = 0; g < 8; g++) begin : g_pad
        if (g < NUM_REQ) begin : g_real
            assign valid_ext[g] = req_valid[g];
            assign req_byte[g]  = req_data[8*g +: 8];
        end else begin : g_none
            assign valid_ext[g] = 1'b0;
            assign req_byte[g]  = '0;
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_ready
        assign req_ready[g] = accept && (winner == 3'(g));
    end

    assign bit_end  = (baud_q == BAUD_LAST);
    assign grant_id = grant_id_q;
    assign accept   = (state_q == S_IDLE) && found && !reset;

    // Search from the slot after the last grant, wrapping; first valid wins.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = 3'((32'(last_grant_q) + k) % NUM_REQ);
            if (!found && valid_ext[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            baud_q       <= '0;
            bit_idx_q    <= '0;
            data_q       <= '0;
            last_grant_q <= LAST_INIT;
            grant_id_q   <= '0;
        end else begin
            state_q      <= state_d;
            baud_q       <= baud_d;
            bit_idx_q    <= bit_idx_d;
            data_q       <= data_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        baud_d       = baud_q;
        bit_idx_d    = bit_idx_q;
        data_d       = data_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        case (state_q)
            S_IDLE: begin
                baud_d    = '0;
                bit_idx_d = '0;
                if (found) begin
                    state_d      = S_START;
                    data_d       = req_byte[winner];
                    last_grant_d = winner;
                    grant_id_d   = winner;
                end
            end
            S_START: begin
                if (bit_end) begin
                    baud_d  = '0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        bit_idx_d = '0;
`ifdef UART_TX_ARB_PARITY_EN
                        state_d   = S_PARITY;
`else
                        state_d   = S_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
`ifdef UART_TX_ARB_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    baud_d  = '0;
                    state_d = S_STOP;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    baud_d  = '0;
                    state_d = S_IDLE;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                baud_d  = '0;
            end
        endcase
    end

    always_comb begin
        tx         = 1'b1;
        busy       = 1'b1;
        frame_done = 1'b0;
        case (state_q)
            S_IDLE:   busy = 1'b0;
            S_START:  tx   = 1'b0;
            S_DATA:   tx   = data_q[bit_idx_q];
`ifdef UART_TX_ARB_PARITY_EN
            S_PARITY: tx   = ^data_q;
`endif
            S_STOP:   frame_done = bit_end;
            default:  busy = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: a frame-level reference model predicts grants and line
// levels, and a separate serial decoder pops expected bytes when frames complete on tx.
module tb_uart_tx_arbiter;

    localparam int NUM = 4;
    localparam int C   = 4;
`ifdef UART_TX_ARB_PARITY_EN
    localparam int FB  = 11;
`else
    localparam int FB  = 10;
`endif
    localparam int FRAME_CYC = FB * C;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [NUM-1:0]   req_valid = '0;
    logic [8*NUM-1:0] req_data = '0;
    logic [NUM-1:0]   req_ready;
    logic             tx;
    logic             busy;
    logic [2:0]       grant_id;
    logic             frame_done;

    int vectors = 0;
    int miscompares = 0;

    uart_tx_arbiter #(.NUM_REQ(NUM), .CLKS_PER_BIT(C)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .tx(tx), .busy(busy), .grant_id(grant_id),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: line idle until a grant, then busy for exactly FB bit periods.
    logic [7:0]  exp_bytes [$];
    int          m_left = 0;
    int          m_last = NUM - 1;
    int          m_gid  = 0;
    logic [10:0] m_frame = '1;

    always @(negedge clk) begin
        int         win;
        logic [NUM-1:0] exp_rdy;
        logic [7:0] b;
        if (reset) begin
            m_left = 0;
            m_last = NUM - 1;
            m_gid  = 0;
            exp_bytes.delete();
        end else if (m_left == 0) begin
            win = -1;
            exp_rdy = '0;
            for (int k = 1; k <= NUM; k++)
                if (win < 0 && req_valid[(m_last + k) % NUM]) win = (m_last + k) % NUM;
            if (win >= 0) exp_rdy[win] = 1'b1;
            check("req_ready_idle", 32'(req_ready), 32'(exp_rdy));
            check("busy_idle", 32'(busy), 0);
            check("tx_idle", 32'(tx), 1);
            check("frame_done_idle", 32'(frame_done), 0);
            check("grant_id_idle", 32'(grant_id), 32'(m_gid));
            if (win >= 0) begin
                b = req_data[8*win +: 8];
                m_last = win;
                m_gid  = win;
                m_frame = '1;
                m_frame[0] = 1'b0;
                for (int i = 0; i < 8; i++) m_frame[1+i] = b[i];
`ifdef UART_TX_ARB_PARITY_EN
                m_frame[9] = ($countones(b) % 2) == 1;
`endif
                exp_bytes.push_back(b);
                m_left = FRAME_CYC;
            end
        end else begin
            check("busy_frame", 32'(busy), 1);
            check("tx_frame", 32'(tx), 32'(m_frame[(FRAME_CYC - m_left) / C]));
            check("frame_done", 32'(frame_done), 32'(m_left == 1));
            check("req_ready_frame", 32'(req_ready), 0);
            check("grant_id_frame", 32'(grant_id), 32'(m_gid));
            m_left--;
        end
    end

    // Serial monitor: samples tx at bit centres and pops the scoreboard on each complete frame.
    int         dcnt = -1;
    logic [10:0] rx = '0;

    always @(negedge clk) begin
        logic [7:0] e;
        if (reset) begin
            dcnt = -1;
        end else begin
            if (dcnt < 0 && busy) dcnt = 0;
            if (dcnt >= 0) begin
                if (dcnt % C == C / 2) rx[dcnt / C] = tx;
                if (dcnt == FRAME_CYC - 1) begin
                    if (exp_bytes.size() == 0) begin
                        check("rx_queue_empty", 1, 0);
                    end else begin
                        e = exp_bytes.pop_front();
                        check("rx_start", 32'(rx[0]), 0);
                        check("rx_byte", 32'(rx[8:1]), 32'(e));
                        check("rx_stop", 32'(rx[FB-1]), 1);
                    end
                    dcnt = -1;
                end else begin
                    dcnt++;
                end
            end
        end
    end

    task automatic wait_ready(input int idx);
        logic got = 1'b0;
        for (int n = 0; n < 200 && !got; n++) begin
            @(negedge clk);
            if (req_ready[idx]) got = 1'b1;
        end
        check("wait_ready", 32'(got), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        idle_cycles(3);
        reset = 1'b0;
        idle_cycles(3);

        // Single byte 0x6F from requester 0.
        req_data[7:0] = 8'h6F;
        req_valid = 4'b0001;
        wait_ready(0);
        req_valid = '0;
        idle_cycles(FRAME_CYC + 5);

        // Fairness with all requesters held valid, then pointer wrap with only 0 and 2.
        for (int i = 0; i < NUM; i++) req_data[8*i +: 8] = 8'hA0 + 8'(i);
        req_valid = 4'b1111;
        wait_ready(0);
        wait_ready(1);
        wait_ready(2);
        wait_ready(3);
        req_valid = 4'b0101;
        wait_ready(0);
        req_valid = 4'b0100;
        wait_ready(2);
        req_valid = '0;
        idle_cycles(FRAME_CYC + 5);

        // Late request from requester 1 during a frame from requester 0.
        req_data[7:0] = 8'h07;
        req_valid = 4'b0001;
        wait_ready(0);
        req_valid = '0;
        idle_cycles(10);
        req_data[15:8] = 8'h5A;
        req_valid = 4'b0010;
        wait_ready(1);
        req_valid = '0;
        idle_cycles(FRAME_CYC + 5);

        // Reset on cycle 17 of a frame from requester 2; next grant restarts at requester 0.
        req_data[23:16] = 8'hC3;
        req_valid = 4'b0100;
        wait_ready(2);
        req_valid = '0;
        repeat (16) @(posedge clk);
        #1;
        reset = 1'b1;
        idle_cycles(1);
        reset = 1'b0;
        req_valid = 4'b1111;
        wait_ready(0);
        req_valid = '0;
        idle_cycles(FRAME_CYC + 5);

        // Randomized traffic with occasional resets.
        repeat (4000) begin
            req_valid = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) req_valid = '0;
            req_data = $urandom;
            reset = ($urandom_range(0, 999) == 0);
            idle_cycles(1);
        end
        reset = 1'b0;
        req_valid = '0;
        idle_cycles(FRAME_CYC + 10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
